// File: rtl/gpio_link_tx_if.sv
// Producer / far-end signal bundle for the GPIO link transmitter.
// The master side is the producer plus far end; the slave side is the transmitter.
interface gpio_link_tx_if #(
   parameter int DATA_W = 32,
   parameter int LANES  = 4
);
   logic              enable;
   logic [DATA_W-1:0] data_in;
   logic              data_rdy;
   logic              ready;
   logic [LANES-1:0]  gpio_data;
   logic              gpio_strobe;
   logic              gpio_frame;
   logic              gpio_ack;
   logic              done;
   logic              err;

   modport master (
      output enable, data_in, data_rdy, gpio_ack,
      input  ready, gpio_data, gpio_strobe, gpio_frame, done, err
   );

   modport slave (
      input  enable, data_in, data_rdy, gpio_ack,
      output ready, gpio_data, gpio_strobe, gpio_frame, done, err
   );
endinterface

// File: rtl/gpio_link_tx.sv
// Serialises one DATA_W word over LANES GPIO lines, LSB beat first, then waits
// for a synchronised acknowledge from the far end with a bounded timeout.
//
// state    | meaning
// IDLE     | waiting for data_rdy while enabled
// SEND     | shifting beats out, DIV cycles each, frame high
// WAIT_ACK | lanes quiet, waiting up to TIMEOUT cycles for synced ack
module gpio_link_tx #(
   parameter int DATA_W  = 32,
   parameter int LANES   = 4,
   parameter int DIV     = 4,
   parameter int TIMEOUT = 16
) (
   input logic           clock,
   input logic           reset,
   gpio_link_tx_if.slave bus
);
   localparam int BEATS = DATA_W / LANES;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CW    = $clog2(DIV);
   localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;

   state_t            state;
   logic [DATA_W-1:0] shift;
   logic [DATA_W-1:0] shift_nx;
   logic [BW-1:0]     beat;
   logic [CW-1:0]     cyc_cnt;
   logic [TW-1:0]     tmr;
   logic              ack_s1;
   logic              ack_s2;
   logic [LANES-1:0]  data_r;
   logic              strobe_r;
   logic              frame_r;
   logic              done_r;
   logic              err_r;

   assign shift_nx        = shift >> LANES;
   assign bus.ready       = (state == IDLE) && bus.enable;
   assign bus.gpio_data   = data_r;
   assign bus.gpio_strobe = strobe_r;
   assign bus.gpio_frame  = frame_r;
   assign bus.done        = done_r;
   assign bus.err         = err_r;

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         shift    <= '0;
         beat     <= '0;
         cyc_cnt  <= '0;
         tmr      <= '0;
         ack_s1   <= 1'b0;
         ack_s2   <= 1'b0;
         data_r   <= '0;
         strobe_r <= 1'b0;
         frame_r  <= 1'b0;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         ack_s1 <= bus.gpio_ack;
         ack_s2 <= ack_s1;
         done_r <= 1'b0;
         err_r  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.data_rdy && bus.enable) begin
                  shift    <= bus.data_in;
                  beat     <= '0;
                  cyc_cnt  <= '0;
                  data_r   <= bus.data_in[LANES-1:0];
                  strobe_r <= 1'b0;
                  frame_r  <= 1'b1;
                  state    <= SEND;
               end
            end
            SEND: begin
               if (!bus.enable) begin
                  state    <= IDLE;
                  shift    <= '0;
                  data_r   <= '0;
                  strobe_r <= 1'b0;
                  frame_r  <= 1'b0;
                  err_r    <= 1'b1;
               end else if (cyc_cnt == CW'(DIV - 1)) begin
                  cyc_cnt  <= '0;
                  strobe_r <= 1'b0;
                  if (beat == BW'(BEATS - 1)) begin
                     state   <= WAIT_ACK;
                     shift   <= '0;
                     data_r  <= '0;
                     frame_r <= 1'b0;
                     tmr     <= TW'(TIMEOUT - 1);
                  end else begin
                     beat   <= beat + 1'b1;
                     shift  <= shift_nx;
                     data_r <= shift_nx[LANES-1:0];
                  end
               end else begin
                  cyc_cnt  <= cyc_cnt + 1'b1;
                  // strobe covers the second half of every beat
                  strobe_r <= (cyc_cnt >= CW'(DIV / 2 - 1));
               end
            end
            WAIT_ACK: begin
               // ack wins over a simultaneous timeout
               if (!bus.enable) begin
                  err_r <= 1'b1;
                  state <= IDLE;
               end else if (ack_s2) begin
                  done_r <= 1'b1;
                  state  <= IDLE;
               end else if (tmr == '0) begin
                  err_r <= 1'b1;
                  state <= IDLE;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gpio_link_tx.sv
// Scoreboard bench for gpio_link_tx: two instances (default and 16/1/2 narrow),
// frames planned at accept time from a beat/timing model, checked by monitors.
module tb_gpio_link_tx;
   localparam int TMO = 16;

   typedef struct {
      int         d;
      logic [3:0] data;
      logic       strobe;
      int         c;
   } beat_t;

   typedef struct {
      int d;
      bit is_err;
      int c;
   } evt_t;

   logic        clk = 1'b0;
   logic        rst  [2];
   logic        en   [2];
   logic        rdy  [2];
   logic [31:0] din  [2];
   logic        ack  [2];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   beat_t       beat_q[$];
   evt_t        evt_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gpio_link_tx_if #(.DATA_W(32), .LANES(4)) bus_a ();
   gpio_link_tx_if #(.DATA_W(16), .LANES(1)) bus_b ();

   assign bus_a.enable   = en[0];
   assign bus_a.data_rdy = rdy[0];
   assign bus_a.data_in  = din[0];
   assign bus_a.gpio_ack = ack[0];
   assign bus_b.enable   = en[1];
   assign bus_b.data_rdy = rdy[1];
   assign bus_b.data_in  = din[1][15:0];
   assign bus_b.gpio_ack = ack[1];

   gpio_link_tx #(.DATA_W(32), .LANES(4), .DIV(4), .TIMEOUT(TMO)) dut_a (
      .clock(clk), .reset(rst[0]), .bus(bus_a));
   gpio_link_tx #(.DATA_W(16), .LANES(1), .DIV(2), .TIMEOUT(TMO)) dut_b (
      .clock(clk), .reset(rst[1]), .bus(bus_b));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
   endtask

   task automatic fail(input string name, input int d);
      n_checks++;
      $display("FAIL %s dut=%0d cycle=%0d actual=present required=absent", name, d, cyc);
   endtask

   task automatic mon(input int d, input logic frame, input logic [3:0] data,
                      input logic strobe, input logic done, input logic err);
      beat_t b;
      evt_t  e;
      while (beat_q.size() > 0 && beat_q[0].d == d && beat_q[0].c < cyc) begin
         n_checks++;
         $display("FAIL beat_missing dut=%0d cycle=%0d actual=absent required=beat@%0d", d, cyc, beat_q[0].c);
         void'(beat_q.pop_front());
      end
      while (evt_q.size() > 0 && evt_q[0].d == d && evt_q[0].c < cyc) begin
         n_checks++;
         $display("FAIL evt_missing dut=%0d cycle=%0d actual=absent required=%s@%0d", d, cyc,
                  evt_q[0].is_err ? "err" : "done", evt_q[0].c);
         void'(evt_q.pop_front());
      end
      if (frame) begin
         if (beat_q.size() > 0 && beat_q[0].d == d && beat_q[0].c == cyc) begin
            b = beat_q.pop_front();
            chk("beat_data", {60'd0, data}, {60'd0, b.data});
            chk("beat_strobe", {63'd0, strobe}, {63'd0, b.strobe});
         end else fail("beat_unexpected", d);
      end else begin
         chk("idle_lanes", {59'd0, data, strobe}, 64'd0);
      end
      if (done || err) begin
         chk("done_err_excl", {63'd0, done & err}, 64'd0);
         if (evt_q.size() > 0 && evt_q[0].d == d && evt_q[0].c == cyc) begin
            e = evt_q.pop_front();
            chk("evt_kind_err", {63'd0, err}, {63'd0, e.is_err});
         end else fail(done ? "done_unexpected" : "err_unexpected", d);
      end
   endtask

   always @(negedge clk) mon(0, bus_a.gpio_frame, bus_a.gpio_data, bus_a.gpio_strobe, bus_a.done, bus_a.err);
   always @(negedge clk) mon(1, bus_b.gpio_frame, {3'd0, bus_b.gpio_data}, bus_b.gpio_strobe, bus_b.done, bus_b.err);

   function automatic logic get_ready(input int d);
      return (d == 0) ? bus_a.ready : bus_b.ready;
   endfunction

   // mode 0: ack raised arg cycles into WAIT_ACK; 1: no ack;
   // 2: enable dropped at frame cycle arg; 3: reset at frame cycle arg
   task automatic run_frame(input int d, input logic [31:0] w, input int mode, input int arg);
      int    l, dv, f, n, last, nend, cut;
      beat_t b;
      evt_t  e;
      l  = (d == 0) ? 4 : 1;
      dv = (d == 0) ? 4 : 2;
      f  = ((d == 0) ? 32 : 16) / l * dv;
      @(negedge clk);
      din[d] = w;
      rdy[d] = 1'b1;
      chk("ready_before", {63'd0, get_ready(d)}, 64'd1);
      @(posedge clk);
      #1;
      n = cyc;
      rdy[d] = 1'b0;
      last = (mode >= 2 && arg < f - 1) ? arg : f - 1;
      for (int i = 0; i <= last; i++) begin
         b.d      = d;
         b.data   = 4'((w >> ((i / dv) * l)) & ((32'd1 << l) - 1));
         b.strobe = (i % dv) >= dv / 2;
         b.c      = n + i;
         beat_q.push_back(b);
      end
      e.d = d;
      if (mode == 0 && arg + 2 <= TMO - 1) begin
         e.is_err = 1'b0; e.c = n + f + arg + 3; evt_q.push_back(e);
      end else if (mode <= 1) begin
         e.is_err = 1'b1; e.c = n + f + TMO; evt_q.push_back(e);
      end else if (mode == 2) begin
         e.is_err = 1'b1; e.c = n + arg + 1; evt_q.push_back(e);
      end
      nend = (mode <= 1) ? f + TMO + 4 : arg + 1;
      cut  = (mode <= 1) ? f - 2 : arg;
      for (int j = 0; j < nend; j++) begin
         @(negedge clk);
         if (j == 1) chk("ready_busy", {63'd0, get_ready(d)}, 64'd0);
         if (j < cut && j < f - 2) begin
            rdy[d] = 1'($urandom);
            din[d] = $urandom;
         end else rdy[d] = 1'b0;
         if (j < f - 4) ack[d] = 1'($urandom);
         else ack[d] = (mode == 0 && j >= f + arg);
         if (mode == 2 && j == arg) en[d] = 1'b0;
         if (mode == 3 && j == arg) rst[d] = 1'b1;
      end
      @(negedge clk);
      rdy[d] = 1'b0;
      ack[d] = 1'b0;
      if (mode == 2) begin
         repeat (3) begin
            @(negedge clk);
            chk("ready_while_disabled", {63'd0, get_ready(d)}, 64'd0);
         end
         en[d] = 1'b1;
         @(negedge clk);
         chk("ready_reenabled", {63'd0, get_ready(d)}, 64'd1);
      end else if (mode == 3) begin
         rst[d] = 1'b0;
         @(negedge clk);
         chk("ready_after_reset", {63'd0, get_ready(d)}, {63'd0, en[d]});
      end else begin
         chk("ready_after_frame", {63'd0, get_ready(d)}, 64'd1);
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int mode, arg, f;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; en[d] = 1'b1; rdy[d] = 1'b0; din[d] = '0; ack[d] = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("reset_frame_a", {63'd0, bus_a.gpio_frame}, 64'd0);
      chk("reset_done_err_b", {62'd0, bus_b.done, bus_b.err}, 64'd0);
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      @(negedge clk);
      chk("ready_post_reset_a", {63'd0, bus_a.ready}, 64'd1);
      chk("ready_post_reset_b", {63'd0, bus_b.ready}, 64'd1);

      run_frame(0, 32'h87654321, 0, 3);
      run_frame(0, 32'h87654321, 1, 0);
      run_frame(0, 32'h87654321, 2, 12);
      run_frame(0, 32'h87654321, 3, 20);
      run_frame(0, 32'h87654321, 0, 0);
      run_frame(1, 32'h0000A5C3, 0, 1);
      run_frame(1, 32'h0000A5C3, 0, TMO - 3);
      run_frame(1, 32'h0000A5C3, 0, TMO - 2);

      for (int t = 0; t < 24; t++) begin
         int d;
         d    = (t % 3 == 2) ? 1 : 0;
         f    = (d == 0) ? 32 : 32;
         mode = $urandom_range(0, 3);
         case (mode)
            0:       arg = $urandom_range(0, TMO);
            1:       arg = 0;
            default: arg = $urandom_range(0, f + TMO - 1);
         endcase
         run_frame(d, $urandom, mode, arg);
      end

      repeat (4) @(negedge clk);
      chk("leftover_beats", 64'(beat_q.size()), 64'd0);
      chk("leftover_events", 64'(evt_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/gpio_link_tx.md
GPIO_LINK_TX -- requirements
Module: gpio_link_tx

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, payload word width in bits; SHALL be a multiple of LANES.
REQ-002 SHALL provide parameter LANES, default 4, number of parallel GPIO data lanes.
REQ-003 SHALL provide parameter DIV, default 4, clock cycles per beat; SHALL be even and >= 2.
REQ-004 SHALL provide parameter TIMEOUT, default 16, maximum cycles in WAIT_ACK; SHALL be >= 1.
REQ-005 SHALL have one clock; reset is synchronous and active-high (ports named clock and reset).
REQ-006 clock  input  1  master clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  link enable (FPGA state); low blocks accepts and aborts active frames.
REQ-009 data_in  input  DATA_W  payload word, sampled on accept.
REQ-010 data_rdy  input  1  payload valid from producer.
REQ-011 ready  output  1  high only in IDLE with enable=1; accept = data_rdy & ready at a rising edge.
REQ-012 gpio_data  output  LANES  current beat data lanes.
REQ-013 gpio_strobe  output  1  beat-valid strobe to far end.
REQ-014 gpio_frame  output  1  high for the whole SEND phase.
REQ-015 gpio_ack  input  1  asynchronous acknowledge from far end.
REQ-016 done  output  1  one-cycle pulse on successful acknowledged frame.
REQ-017 err  output  1  one-cycle pulse on ack timeout or abort.

Function
REQ-018 SHALL implement states IDLE, SEND, WAIT_ACK; BEATS = DATA_W/LANES.
REQ-019 IDLE: on accept, SHALL capture data_in into a shift register, clear beat and cycle counters, and enter SEND on the next cycle.
REQ-020 Latency: SHALL drive gpio_frame=1 and gpio_data=data_in[LANES-1:0] in the first cycle after the accept edge.
REQ-021 SEND: each beat SHALL last exactly DIV cycles; gpio_data SHALL remain stable for the whole beat; beats SHALL be sent LSB-first (beat k carries bits [k*LANES +: LANES]).
REQ-022 gpio_strobe SHALL be high in beat cycles DIV/2 .. DIV-1 and low in cycles 0 .. DIV/2-1.
REQ-023 After the last cycle of beat BEATS-1, SHALL enter WAIT_ACK; gpio_frame, gpio_strobe and gpio_data SHALL be 0 there. Total SEND duration = BEATS*DIV cycles.
REQ-024 gpio_ack SHALL pass through a 2-flop synchroniser; only the synchronised value SHALL be used; ack seen outside WAIT_ACK SHALL be ignored.
REQ-025 WAIT_ACK: synchronised ack=1 SHALL pulse done for one cycle and return to IDLE; ack and timeout in the same cycle SHALL count as success.
REQ-026 WAIT_ACK: after TIMEOUT cycles without ack, SHALL pulse err for one cycle and return to IDLE.
REQ-027 enable=0 in SEND or WAIT_ACK SHALL abort: next cycle state IDLE, gpio_frame=0, err pulses once, captured word discarded.
REQ-028 data_rdy while ready=0 SHALL be ignored without side effects; no queueing.
REQ-029 done and err SHALL never be high in the same cycle.
REQ-030 Beat and cycle counters SHALL be sized for BEATS and DIV respectively and SHALL not wrap within a frame.

Reset
REQ-031 reset=1 at a rising edge SHALL force state IDLE; gpio_data, gpio_strobe, gpio_frame, done, err SHALL be 0; counters, shift register and synchroniser flops SHALL be cleared.
REQ-032 reset mid-frame SHALL abandon the frame silently (no err pulse); ready SHALL equal enable in the first cycle after reset deasserts.

Verification
REQ-033 Defaults, enable=1, data_in=32'h87654321, one-cycle data_rdy -> frame high 32 cycles; gpio_data 1,2,3,4,5,6,7,8 each 4 cycles; strobe high 2 of every 4 cycles.
REQ-034 Same frame, gpio_ack raised 3 cycles into WAIT_ACK -> done pulses once (after 2-cycle sync delay), ready returns high next cycle.
REQ-035 Same frame, gpio_ack held low -> err pulses exactly 16 cycles into WAIT_ACK, state IDLE, done never high.
REQ-036 enable dropped at beat 3 -> gpio_frame low next cycle, single err pulse, ready stays low until enable=1.
REQ-037 reset asserted during SEND beat 5 -> all outputs 0 next cycle, no err; new accept afterwards transmits cleanly.
REQ-038 Parameters DATA_W=16, LANES=1, DIV=2, data_in=16'hA5C3, ack prompt -> 16 beats LSB-first, 32-cycle frame, done once.
